multdiv_issue_ctrl: RTL and testbench
=====================================

// Module: multdiv_issue_ctrl
// PURPOSE
//  Execute-stage initiator for the multdiv unit. Detects a mult/div instruction, latches its operands and issues one
//  ctrl_MULT/ctrl_DIV pulse. Stalls the pipeline until data_resultRDY, then presents result/exception for writeback.
//  Handles flush while an operation is in flight (drains it) and flags an unit that never responds (watchdog).
// PARAMETERS
//  TIMEOUT  64  max cycles in WAIT/DRAIN before forced completion; must be >= 2
//  CNT_W    7   watchdog counter width; requires 2**CNT_W > TIMEOUT
// PORTS
//  clock         in   1   rising-edge clock
//  reset         in   1   asynchronous, active-low; 0 forces the reset state immediately
//  in_valid      in   1   execute-stage instruction valid
//  in_is_mult    in   1   instruction is mul
//  in_is_div     in   1   instruction is div
//  in_opA        in   32  rs operand
//  in_opB        in   32  rt operand
//  in_rd         in   5   destination register
//  flush         in   1   squash the execute-stage instruction (branch/jump taken)
//  stall         out  1   hold F/D/X stages (combinational)
//  md_operandA   out  32  to multdiv data_operandA (registered, stable ISSUE..end of op)
//  md_operandB   out  32  to multdiv data_operandB
//  md_ctrl_MULT  out  1   one-cycle start pulse, mult
//  md_ctrl_DIV   out  1   one-cycle start pulse, div
//  md_result     in   32  multdiv data_result
//  md_exception  in   1   multdiv data_exception
//  md_resultRDY  in   1   multdiv data_resultRDY
//  wb_valid      out  1   one-cycle result valid for writeback
//  wb_rd         out  5   destination for wb_data
//  wb_data       out  32  result; 0 when wb_exception=1
//  wb_exception  out  1   overflow, div-by-0, illegal op, or timeout
//  busy          out  1   state != IDLE
//  timeout       out  1   sticky; set on any watchdog expiry, cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE; all registered outputs 0; counter 0; timeout 0.
//  States: IDLE, ISSUE, WAIT, DONE, DRAIN.
//  IDLE: accept = in_valid & ~flush & (in_is_mult | in_is_div).
//   - Accept with exactly one op bit set:
//     - latch opA/opB -> md_operandA/B, latch rd and op type; go to ISSUE.
//   - Both op bits set (illegal): no issue; go to DONE with wb_exception=1, wb_data=0.
//  ISSUE: exactly 1 cycle; md_ctrl_MULT or md_ctrl_DIV=1 per latched op.
//   - md_resultRDY ignored here (stale from previous op).
//   - Clear counter.
//   - Go to WAIT, or to DRAIN if flush=1.
//  WAIT: counter increments each cycle.
//   - md_resultRDY=1: capture md_result/md_exception; go to DONE.
//     - If md_exception=1: wb_data=0.
//   - Else if counter==TIMEOUT-1: go to DONE with wb_exception=1, wb_data=0; set timeout.
//   - flush=1 (takes priority over RDY/timeout): go to DRAIN.
//  DONE: 1 cycle; wb_valid = ~flush (combinational gate). Go to IDLE.
//   - wb_rd/wb_data/wb_exception hold their values until the next DONE.
//  DRAIN: multdiv cannot be aborted; wait for md_resultRDY or watchdog expiry, discard result.
//   - Go to IDLE; timeout set if the watchdog expired.
//   - No wb_valid from DRAIN.
//  stall = ISSUE | WAIT | (IDLE & accept) | (DRAIN & in_valid & (in_is_mult|in_is_div)).
//   - stall=0 in DONE, so the instruction retires in the wb_valid cycle.
//   - Non-md instructions flow during DRAIN.
//  Latency: accept at cycle T; ctrl pulse at T+1. If RDY first seen at T+1+k (k>=1), wb_valid at T+2+k.
//  md_ctrl_* never asserted outside ISSUE; never two pulses per instruction.
//  A new op is accepted no earlier than the cycle DONE/DRAIN returns to IDLE.
//  Reset asserted mid-operation: return to IDLE at once; the multdiv's pending result is ignored.
// TESTING
//  1 mult, opA=6, opB=-7, RDY 17 cycles after pulse -> single ctrl_MULT pulse; stall high through WAIT.
//    Then wb_valid one cycle with wb_data=0xFFFFFFD6, wb_exception=0.
//  2 div, opA=7, opB=0, multdiv returns exception=1 -> wb_exception=1, wb_data=0, wb_rd=latched rd.
//  3 flush 3 cycles into WAIT, then a new div 100/-7 presented -> no wb_valid for the first op.
//    New op stalls in DRAIN until the old RDY arrives; second op yields wb_data=0xFFFFFFF2 (-14).
//  4 RDY high during ISSUE cycle, then low for 5 cycles, then high -> ISSUE-cycle RDY ignored; wb_valid follows the later RDY.
//  5 RDY never asserted, TIMEOUT=64 -> wb_valid with wb_exception=1 exactly 65 cycles after the ctrl pulse.
//    timeout=1 and stays 1 until reset.
//  6 reset low mid-WAIT -> busy, stall, wb_valid, timeout all 0 immediately; next op issues normally.

Source files
------------

// File: rtl/multdiv_issue_ctrl_if.sv
// Execute-stage <-> multdiv issue controller signal bundle.
// The controller takes the slave view; the pipeline/multdiv side takes the master view.
interface multdiv_issue_ctrl_if;
  logic        in_valid;
  logic        in_is_mult;
  logic        in_is_div;
  logic [31:0] in_opA;
  logic [31:0] in_opB;
  logic [4:0]  in_rd;
  logic        flush;
  logic        stall;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;
  logic        busy;
  logic        timeout;

  modport slave (
    input  in_valid, in_is_mult, in_is_div, in_opA, in_opB, in_rd, flush,
           md_result, md_exception, md_resultRDY,
    output stall, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
           wb_valid, wb_rd, wb_data, wb_exception, busy, timeout
  );

  modport master (
    output in_valid, in_is_mult, in_is_div, in_opA, in_opB, in_rd, flush,
           md_result, md_exception, md_resultRDY,
    input  stall, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
           wb_valid, wb_rd, wb_data, wb_exception, busy, timeout
  );
endinterface

// File: rtl/multdiv_issue_ctrl.sv
// Issues one mult/div start pulse per execute-stage instruction, stalls until the
// multdiv result is ready, drains squashed operations and guards against a dead unit.
module multdiv_issue_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input logic                 clock,
  input logic                 reset,
  multdiv_issue_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic             op_div_q, op_div_d;
  logic [4:0]       rd_q, rd_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             wb_exc_q, wb_exc_d;
  logic             timeout_q, timeout_d;

  logic is_md, accept, expired;

  assign is_md   = bus.in_is_mult | bus.in_is_div;
  assign accept  = bus.in_valid & ~bus.flush & is_md;
  // The budget spans WAIT and DRAIN together, so a late flush cannot step past the limit.
  assign expired = (cnt_q >= CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    op_div_d  = op_div_q;
    rd_d      = rd_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wb_exc_d  = wb_exc_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.in_is_mult & bus.in_is_div) begin
            state_d   = S_DONE;
            wb_rd_d   = bus.in_rd;
            wb_data_d = '0;
            wb_exc_d  = 1'b1;
          end else begin
            state_d  = S_ISSUE;
            opa_d    = bus.in_opA;
            opb_d    = bus.in_opB;
            op_div_d = bus.in_is_div;
            rd_d     = bus.in_rd;
          end
        end
      end
      S_ISSUE: begin
        // Any resultRDY seen here belongs to the previous operation.
        cnt_d   = '0;
        state_d = bus.flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.flush) begin
          state_d = S_DRAIN;
        end else if (bus.md_resultRDY) begin
          state_d   = S_DONE;
          wb_rd_d   = rd_q;
          wb_exc_d  = bus.md_exception;
          wb_data_d = bus.md_exception ? '0 : bus.md_result;
        end else if (expired) begin
          state_d   = S_DONE;
          wb_rd_d   = rd_q;
          wb_exc_d  = 1'b1;
          wb_data_d = '0;
          timeout_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.md_resultRDY) begin
          state_d = S_IDLE;
        end else if (expired) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      op_div_q  <= 1'b0;
      rd_q      <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      wb_exc_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      op_div_q  <= op_div_d;
      rd_q      <= rd_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      wb_exc_q  <= wb_exc_d;
      timeout_q <= timeout_d;
    end
  end

  // Non-md instructions keep flowing while a squashed operation drains.
  assign bus.stall = (state_q == S_ISSUE) | (state_q == S_WAIT) |
                     ((state_q == S_IDLE) & accept) |
                     ((state_q == S_DRAIN) & bus.in_valid & is_md);

  assign bus.md_operandA  = opa_q;
  assign bus.md_operandB  = opb_q;
  assign bus.md_ctrl_MULT = (state_q == S_ISSUE) & ~op_div_q;
  assign bus.md_ctrl_DIV  = (state_q == S_ISSUE) &  op_div_q;
  assign bus.wb_valid     = (state_q == S_DONE) & ~bus.flush;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_exception = wb_exc_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Randomized bench for multdiv_issue_ctrl with a transaction-level timing/result model.
module tb_multdiv_issue_ctrl;
  localparam int TIMEOUT = 64;

  logic clock = 1'b0;
  logic reset;

  multdiv_issue_ctrl_if bus ();

  multdiv_issue_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic        exp_timeout;
  logic [4:0]  g_wb_rd;
  logic [31:0] g_wb_data;
  logic        g_wb_exc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_hold();
    chk("wb_rd", 32'(bus.wb_rd), 32'(g_wb_rd));
    chk("wb_data", bus.wb_data, g_wb_data);
    chk("wb_exception", 32'(bus.wb_exception), 32'(g_wb_exc));
    chk("timeout", 32'(bus.timeout), 32'(exp_timeout));
  endtask

  // Reference multdiv: 32-bit signed product/quotient with overflow and div-by-zero flags.
  function automatic void md_model(input logic is_div, input logic signed [31:0] a,
                                   input logic signed [31:0] b,
                                   output logic [31:0] res, output logic exc);
    longint p;
    if (!is_div) begin
      p   = longint'(a) * longint'(b);
      res = p[31:0];
      exc = (p != longint'($signed(p[31:0])));
    end else if (b == 0) begin
      res = 32'hDEADBEEF;
      exc = 1'b1;
    end else if (a == 32'sh80000000 && b == -32'sd1) begin
      res = a;
      exc = 1'b1;
    end else begin
      res = a / b;
      exc = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Instruction presented at c=0, pulse at c=1, first RDY at c=1+k (k>TIMEOUT: never).
  task automatic run_op(input logic is_mult, input logic is_div, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int k,
                        input logic stale, input logic flush_done);
    logic [31:0] res, exp_data;
    logic        exc, exp_exc, illegal, timed_out, rdy_now;
    int          done;
    illegal   = is_mult & is_div;
    timed_out = 1'b0;
    md_model(is_div, a, b, res, exc);
    if (illegal) begin
      done = 1; exp_exc = 1'b1; exp_data = '0;
    end else if (k <= TIMEOUT) begin
      done = 2 + k; exp_exc = exc; exp_data = exc ? 32'h0 : res;
    end else begin
      done = 2 + TIMEOUT; exp_exc = 1'b1; exp_data = '0; timed_out = 1'b1;
    end
    for (int c = 0; c <= done; c++) begin
      bus.in_valid   = 1'b1;
      bus.in_is_mult = is_mult;
      bus.in_is_div  = is_div;
      bus.in_opA     = a;
      bus.in_opB     = b;
      bus.in_rd      = rd;
      bus.flush      = flush_done && (c == done);
      rdy_now = !illegal && ((c == 1 && stale) || (k <= TIMEOUT && c == 1 + k));
      bus.md_resultRDY = rdy_now;
      bus.md_result    = (rdy_now && c != 1) ? res : $urandom;
      bus.md_exception = (rdy_now && c != 1) ? exc : 1'($urandom);
      #4;
      if (c == done) begin
        g_wb_rd = rd; g_wb_data = exp_data; g_wb_exc = exp_exc;
        if (timed_out) exp_timeout = 1'b1;
      end
      chk("stall", 32'(bus.stall), 32'(c < done));
      chk("busy", 32'(bus.busy), 32'(c > 0));
      chk("ctrl_MULT", 32'(bus.md_ctrl_MULT), 32'(!illegal && c == 1 && is_mult));
      chk("ctrl_DIV", 32'(bus.md_ctrl_DIV), 32'(!illegal && c == 1 && is_div));
      chk("wb_valid", 32'(bus.wb_valid), 32'(c == done && !flush_done));
      if (c == 1 && !illegal) begin
        chk("md_operandA", bus.md_operandA, a);
        chk("md_operandB", bus.md_operandB, b);
      end
      chk_hold();
      tick();
    end
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.md_resultRDY = 1'b0;
  endtask

  // Op1 flushed at cycle f (ISSUE or WAIT); old RDY at r; op2 presented from f+2 and
  // accepted at r+1 by the run_op call that follows.
  task automatic run_flush(input logic is_div1, input logic [31:0] a1, input logic [31:0] b1,
                           input int f, input int r, input logic is_div2,
                           input logic [31:0] a2, input logic [31:0] b2, input logic [4:0] rd2);
    for (int c = 0; c <= r; c++) begin
      if (c <= f) begin
        bus.in_valid = 1'b1; bus.in_is_mult = ~is_div1; bus.in_is_div = is_div1;
        bus.in_opA = a1; bus.in_opB = b1; bus.in_rd = 5'd31;
        bus.flush = (c == f);
      end else if (c == f + 1) begin
        bus.in_valid = 1'b1; bus.in_is_mult = 1'b0; bus.in_is_div = 1'b0;
        bus.flush = 1'b0;
      end else begin
        bus.in_valid = 1'b1; bus.in_is_mult = ~is_div2; bus.in_is_div = is_div2;
        bus.in_opA = a2; bus.in_opB = b2; bus.in_rd = rd2;
        bus.flush = 1'b0;
      end
      bus.md_resultRDY = (c == r);
      bus.md_result    = $urandom;
      bus.md_exception = 1'($urandom);
      #4;
      chk("drain_stall", 32'(bus.stall), 32'(c != f + 1));
      chk("drain_busy", 32'(bus.busy), 32'(c > 0));
      chk("drain_MULT", 32'(bus.md_ctrl_MULT), 32'(c == 1 && !is_div1));
      chk("drain_DIV", 32'(bus.md_ctrl_DIV), 32'(c == 1 && is_div1));
      chk("drain_wb_valid", 32'(bus.wb_valid), 32'(0));
      chk_hold();
      tick();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'($urandom); bus.in_is_mult = 1'b0; bus.in_is_div = 1'b0;
      bus.flush = 1'b0; bus.md_resultRDY = 1'($urandom);
      #4;
      chk("idle_stall", 32'(bus.stall), 32'(0));
      chk("idle_busy", 32'(bus.busy), 32'(0));
      chk("idle_wb_valid", 32'(bus.wb_valid), 32'(0));
      chk_hold();
      tick();
    end
    bus.md_resultRDY = 1'b0; bus.in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_opnd();
    int v;
    case ($urandom_range(0, 5))
      0:       v = 0;
      1, 2:    v = $urandom;
      default: v = int'($urandom_range(0, 2000)) - 1000;
    endcase
    return 32'(v);
  endfunction

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_is_mult = 1'b0; bus.in_is_div = 1'b0;
    bus.in_opA = '0; bus.in_opB = '0; bus.in_rd = '0; bus.flush = 1'b0;
    bus.md_result = '0; bus.md_exception = 1'b0; bus.md_resultRDY = 1'b0;
    exp_timeout = 1'b0; g_wb_rd = '0; g_wb_data = '0; g_wb_exc = 1'b0;
    #2 reset = 1'b0;
    tick(); tick();
    #4;
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_ctrl", 32'({bus.md_ctrl_MULT, bus.md_ctrl_DIV}), 32'(0));
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'(0));
    chk("rst_operandA", bus.md_operandA, 32'h0);
    chk_hold();
    tick();
    reset = 1'b1;
    idle(2);

    run_op(1'b1, 1'b0, 32'd6, -32'sd7, 5'd3, 17, 1'b0, 1'b0);
    chk("t1_data", g_wb_data, 32'hFFFFFFD6);
    run_op(1'b0, 1'b1, 32'd7, 32'd0, 5'd9, 5, 1'b0, 1'b0);
    idle(1);
    run_flush(1'b0, 32'd12, 32'd5, 4, 10, 1'b1, 32'd100, -32'sd7, 5'd4);
    run_op(1'b0, 1'b1, 32'd100, -32'sd7, 5'd4, 8, 1'b0, 1'b0);
    chk("t3_data", g_wb_data, 32'hFFFFFFF2);
    run_op(1'b1, 1'b0, 32'd1234, 32'd99, 5'd12, 6, 1'b1, 1'b0);
    run_op(1'b0, 1'b1, 32'd50, 32'd3, 5'd20, TIMEOUT + 1, 1'b0, 1'b0);
    idle(2);
    run_op(1'b1, 1'b0, -32'sd3, 32'd11, 5'd21, TIMEOUT, 1'b1, 1'b0);
    run_op(1'b1, 1'b0, 32'h40000000, 32'd4, 5'd22, 1, 1'b0, 1'b0);
    run_op(1'b1, 1'b1, 32'd5, 32'd5, 5'd23, 3, 1'b0, 1'b0);
    run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd24, 2, 1'b0, 1'b1);
    run_flush(1'b1, 32'd9, 32'd3, 1, 5, 1'b0, 32'd7, 32'd8, 5'd25);
    run_op(1'b1, 1'b0, 32'd7, 32'd8, 5'd25, 4, 1'b1, 1'b0);

    // flush in IDLE squashes the md instruction before it is accepted
    bus.in_valid = 1'b1; bus.in_is_mult = 1'b1; bus.in_is_div = 1'b0; bus.flush = 1'b1;
    #4;
    chk("idle_flush_stall", 32'(bus.stall), 32'(0));
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    #4;
    chk("idle_flush_busy", 32'(bus.busy), 32'(0));
    tick();

    for (int n = 0; n < 40; n++) begin
      logic m, d;
      int   sel;
      sel = $urandom_range(0, 11);
      m = (sel <= 6); d = (sel >= 6);
      if ($urandom_range(0, 4) == 0 && sel != 6) begin
        logic [31:0] a2, b2;
        int f;
        a2 = rand_opnd(); b2 = rand_opnd();
        f  = $urandom_range(1, 6);
        run_flush(1'($urandom), rand_opnd(), rand_opnd(), f, f + $urandom_range(2, 10),
                  d, a2, b2, 5'($urandom));
        run_op(m, d, a2, b2, 5'($urandom), $urandom_range(1, 30), 1'($urandom), 1'b0);
      end else begin
        run_op(m, d, rand_opnd(), rand_opnd(), 5'($urandom),
               ($urandom_range(0, 15) == 0) ? TIMEOUT + $urandom_range(0, 1) : $urandom_range(1, 30),
               1'($urandom), ($urandom_range(0, 7) == 0));
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    // reset mid-WAIT
    bus.in_valid = 1'b1; bus.in_is_mult = 1'b1; bus.in_is_div = 1'b0;
    bus.in_opA = 32'd3; bus.in_opB = 32'd4; bus.in_rd = 5'd7;
    for (int c = 0; c < 4; c++) tick();
    #4;
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    g_wb_rd = '0; g_wb_data = '0; g_wb_exc = 1'b0; exp_timeout = 1'b0;
    chk("rstw_busy", 32'(bus.busy), 32'(0));
    chk("rstw_stall", 32'(bus.stall), 32'(0));
    chk("rstw_wb_valid", 32'(bus.wb_valid), 32'(0));
    chk("rstw_ctrl", 32'({bus.md_ctrl_MULT, bus.md_ctrl_DIV}), 32'(0));
    chk_hold();
    tick();
    reset = 1'b1;
    idle(3);
    run_op(1'b0, 1'b1, -32'sd81, 32'd9, 5'd17, 12, 1'b0, 1'b0);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
